// File: rtl/divider_iterative.sv
// rtl/divider_iterative.sv - iterative unsigned restoring divider, one quotient bit per clock
module divider_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] part_rem;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Trial subtraction is one bit wider than the operands so the borrow lands in trial[WIDTH].
  always_comb begin
    trial    = {part_rem, dividend[WIDTH-1]} - {1'b0, divisor};
    rem_next = trial[WIDTH] ? {part_rem[WIDTH-2:0], dividend[WIDTH-1]} : trial[WIDTH-1:0];
    quo_next = {dividend[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      q         <= '0;
      rem       <= '0;
      divisor   <= '0;
      dividend  <= '0;
      part_rem  <= '0;
      count     <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (valid_in) begin
            divisor  <= b;
            dividend <= a;
            part_rem <= '0;
            count    <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= BUSY;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        BUSY: begin
          part_rem <= rem_next;
          dividend <= quo_next;
          count    <= count - CW'(1);
          // Results are published only here, so q/rem hold through the next operation.
          if (count == CW'(1)) begin
            q         <= quo_next;
            rem       <= rem_next;
            valid_out <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_iterative.sv
// tb/tb_divider_iterative.sv - scoreboard bench for divider_iterative
module tb_divider_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         valid_out;
  logic         busy;
  logic [W-1:0] q;
  logic [W-1:0] rem;

  divider_iterative #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .busy      (busy),
    .q         (q),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   n_push = 0;
  int   n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Output side of the scoreboard: every valid_out must match the oldest pending start.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", {63'd0, valid_out}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", {32'd0, q}, {32'd0, e.q});
        chk("rem", {32'd0, rem}, {32'd0, e.r});
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge: the following posedge accepts, then valid_out after W more edges.
  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_t e;
    e.q   = (eb == 0) ? '1 : ea / eb;
    e.r   = (eb == 0) ? ea : ea % eb;
    e.cyc = cyc + 1 + W;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic start(input logic [W-1:0] sa, input logic [W-1:0] sb_in, input bit expect_it);
    @(negedge clk);
    a = sa;
    b = sb_in;
    valid_in = 1'b1;
    if (expect_it) push_exp(sa, sb_in);
    @(negedge clk);
    valid_in = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (3) @(negedge clk);
    chk("reset_valid_out", {63'd0, valid_out}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_q", {32'd0, q}, 64'd0);
    chk("reset_rem", {32'd0, rem}, 64'd0);
    reset = 1'b0;

    start(32'd100, 32'd7, 1'b1);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done("basic_done");
    chk("busy_idle", {63'd0, busy}, 64'd0);

    start(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done("div_by_one");
    start(32'd5, 32'd9, 1'b1);
    wait_done("a_lt_b");
    start(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("a_eq_b");
    start(32'h1234_5678, 32'd0, 1'b1);
    wait_done("div_by_zero");

    // A start request during BUSY must be dropped.
    start(32'd20, 32'd3, 1'b1);
    repeat (5) @(negedge clk);
    start(32'd999, 32'd1, 1'b0);
    wait_done("ignore_busy");
    repeat (40) @(negedge clk);
    chk("hold_q", {32'd0, q}, 64'd6);
    chk("hold_rem", {32'd0, rem}, 64'd2);
    chk("idle_after_ignore", {63'd0, busy}, 64'd0);

    // Back-to-back: re-issue during the DONE cycle.
    start(32'd1000, 32'd10, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (valid_out) break;
      @(negedge clk);
    end
    chk("b2b_reach_done", {63'd0, valid_out}, 64'd1);
    a = 32'd50;
    b = 32'd5;
    valid_in = 1'b1;
    push_exp(32'd50, 32'd5);
    @(negedge clk);
    valid_in = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done("b2b_done");

    // Reset mid-operation.
    start(32'd77, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid_out", {63'd0, valid_out}, 64'd0);
    chk("abort_q", {32'd0, q}, 64'd0);
    chk("abort_rem", {32'd0, rem}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_out_after_abort", {63'd0, valid_out}, 64'd0);
    start(32'd77, 32'd3, 1'b1);
    wait_done("after_abort");

    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      start(ra, rb, 1'b1);
      wait_done("rand_done");
    end

    chk("out_count", 64'(n_out), 64'(n_push));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divider_iterative.md
# divider_iterative

Iterative unsigned integer divider. It computes quotient and remainder of two WIDTH-bit operands using restoring division, one quotient bit per clock. It is the inverse-operation counterpart of the iterative multiplier in the functional-units set, and uses the same single-cycle `valid_in` / `valid_out` handshake, so the two are interchangeable behind one issue interface.

## Interface

- `WIDTH`, default 32: operand, quotient and remainder width. Legal range 2–64.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  start request; sampled only while the unit is not busy.
- `a`  in  WIDTH  dividend (unsigned); sampled on the accepting edge.
- `b`  in  WIDTH  divisor (unsigned); sampled on the accepting edge.
- `valid_out`  out  1  one-cycle pulse; `q` and `rem` are valid while it is high.
- `busy`  out  1  high while an operation is in progress.
- `q`  out  WIDTH  quotient; holds its value until the next completion.
- `rem`  out  WIDTH  remainder; holds its value until the next completion.

## Operation

- **Reset.** One clock domain; reset is asynchronous and active-high. Reset forces state IDLE, `valid_out`=0, `busy`=0, `q`=0, `rem`=0, and clears all internal registers.
- **State machine.** States are IDLE, BUSY and DONE.
  - IDLE: if `valid_in`=1 at the edge, capture `a` and `b`, clear the partial remainder, load the iteration counter with WIDTH, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: perform one restoring step per edge.
    - Shift {partial remainder, dividend} left by 1.
    - Trial-subtract the divisor from the upper half, computed at WIDTH+1 bits so there is no overflow.
    - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
    - Decrement the counter. When the step being executed is the last one (counter was 1), go to DONE.
  - DONE: `valid_out`=1 for exactly this cycle, and `q`/`rem` are already updated.
    - If `valid_in`=1 at the edge, accept new operands and go to BUSY (back-to-back operation).
    - Otherwise go to IDLE.
- **Output registers.** `q` and `rem` are output registers written only on the BUSY→DONE edge. They keep the previous result during a following operation.
- **Busy behaviour.** `valid_in` is ignored while in BUSY. Operand inputs may change freely after the accepting edge.
- **Divide by zero** (`b`=0): no special path.
  - The restoring algorithm naturally yields `q` = all ones and `rem` = `a`; this is the required result.
  - Latency is unchanged, and there is no error flag.
- **Special cases.**
  - `a` < `b` gives `q`=0, `rem`=`a`.
  - `a`=`b`≠0 gives `q`=1, `rem`=0.
  - `b`=1 gives `q`=`a`, `rem`=0.
- **Arithmetic invariant.** All arithmetic is unsigned. For `b`≠0: `a` = `q`·`b` + `rem`, with `rem` < `b`.

## Timing

- **Accept.** Operands are accepted at edge N (state is IDLE or DONE, `valid_in`=1).
  - `busy` is high from after edge N until after edge N+WIDTH.
  - The state enters DONE after edge N+WIDTH.
  - `valid_out` is high during the cycle between edges N+WIDTH and N+WIDTH+1.
- **Latency.** Acceptance edge to `valid_out` rising is WIDTH cycles (32 at default). It does not depend on the data.
- **Throughput.** One result per WIDTH+1 cycles when `valid_in` is asserted in every DONE cycle.
- **Holding `valid_in`.** If `valid_in` is held high continuously, the unit re-accepts in DONE. A requester that wants exactly one operation must drop `valid_in` after its accepting edge.
- **Reset mid-operation.** Asynchronous reset in BUSY or DONE aborts immediately. No `valid_out` is produced, and `q`/`rem` read 0.
- **Registered outputs.** `busy` and `valid_out` are registered state decodes, with no combinational path from `valid_in`.

## Test plan

- **Basic divide.** Reset, then `a`=100, `b`=7 with a one-cycle `valid_in` → `valid_out` pulses exactly 32 cycles after the accepting edge, with `q`=14 and `rem`=2. After reset, all outputs read 0.
- **Corner operands.**
  - `a`=0xFFFFFFFF, `b`=1 → `q`=0xFFFFFFFF, `rem`=0.
  - `a`=5, `b`=9 → `q`=0, `rem`=5.
  - `a`=`b`=0x80000000 → `q`=1, `rem`=0.
- **Divide by zero.** `a`=0x12345678, `b`=0 → `q`=0xFFFFFFFF, `rem`=0x12345678, latency 32.
- **Busy/back-to-back.**
  - Pulse `valid_in` with new operands mid-operation → it is ignored, and the first result is unchanged.
  - Assert `valid_in` during DONE with `a`=50, `b`=5 → accepted; the next result is `q`=10, `rem`=0 at 33 cycles after the previous accept.
- **Reset mid-operation.** Assert `reset` 10 cycles into an operation → `busy`=0, `q`=0, `rem`=0 immediately, with no `valid_out`. A new operation afterward completes correctly.
- **Random regression.** 100 random (`a`, `b`) pairs, each with `b`≠0 → each satisfies `q`·`b`+`rem`=`a` and `rem`<`b`, with exactly one `valid_out` per accepted start.
